// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and enumerations for the program loader.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // addi x0, x0, 0 -- written in place of any word that cannot be encoded
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Encodings 6 and 7 are illegal and intentionally absent
   typedef enum logic [2:0] {
      K_R      = 3'd0,
      K_IALU   = 3'd1,
      K_LOAD   = 3'd2,
      K_STORE  = 3'd3,
      K_BRANCH = 3'd4,
      K_JAL    = 3'd5
   } kind_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_DONE
   } state_e;

endpackage

// File: rtl/rv_instr_encode.sv
// Combinational field-to-word encoder; flags illegal kinds and out-of-range immediates.
module rv_instr_encode
   import rv_pkg::*;
(
   input  logic               [2:0]  kind,
   input  logic               [4:0]  rd,
   input  logic               [4:0]  rs1,
   input  logic               [4:0]  rs2,
   input  logic               [2:0]  funct3,
   input  logic                      funct7b5,
   input  logic signed        [20:0] imm,
   output logic               [31:0] word,
   output logic                      bad
);

   function automatic logic in_range(input logic signed [20:0] v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

   function automatic logic is_even(input logic signed [20:0] v);
      return !v[0];
   endfunction

   logic [31:0] raw;

   always_comb begin
      raw = NOP;
      bad = 1'b0;
      case (kind)
         K_R: begin
            raw = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
         end
         K_IALU: begin
            raw = {imm[11:0], rs1, funct3, rd, OP_IMM};
            bad = !in_range(imm, -2048, 2047);
         end
         K_LOAD: begin
            raw = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            bad = !in_range(imm, -2048, 2047);
         end
         K_STORE: begin
            raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            bad = !in_range(imm, -2048, 2047);
         end
         K_BRANCH: begin
            raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            bad = !(in_range(imm, -4096, 4094) && is_even(imm));
         end
         K_JAL: begin
            // a 21-bit signed field already spans the whole JAL reach
            raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            bad = !is_even(imm);
         end
         default: begin
            bad = 1'b1;
         end
      endcase
      word = bad ? NOP : raw;
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded RV32I words into instruction memory, holding the core until the program is loaded.
module instr_encoder_loader
   import rv_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_kind,
   input  logic [4:0]          in_rd,
   input  logic [4:0]          in_rs1,
   input  logic [4:0]          in_rs2,
   input  logic [2:0]          in_funct3,
   input  logic                in_funct7b5,
   input  logic [20:0]         in_imm,
   input  logic                in_last,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [31:0]         imem_wdata,
   output logic                cpu_hold,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W:0]     count
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

   state_e              state_q, state_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic [ADDR_W:0]     count_q, count_n;
   logic                err_q, err_n;
   logic [31:0]         word_p1, word_n;
   logic                last_p1, last_n;

   logic signed [20:0]  imm_s;
   logic [31:0]         enc_word;
   logic                enc_bad;

   assign imm_s = $signed(in_imm);

   rv_instr_encode u_encode (
      .kind     (in_kind),
      .rd       (in_rd),
      .rs1      (in_rs1),
      .rs2      (in_rs2),
      .funct3   (in_funct3),
      .funct7b5 (in_funct7b5),
      .imm      (imm_s),
      .word     (enc_word),
      .bad      (enc_bad)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         word_p1 <= '0;
         last_p1 <= 1'b0;
      end else begin
         state_q <= state_n;
         addr_q  <= addr_n;
         count_q <= count_n;
         err_q   <= err_n;
         word_p1 <= word_n;
         last_p1 <= last_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      addr_n   = addr_q;
      count_n  = count_q;
      err_n    = err_q;
      word_n   = word_p1;
      last_n   = last_p1;
      in_ready = 1'b0;
      imem_we  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      cpu_hold = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_n = S_ACCEPT;
               addr_n  = '0;
               count_n = '0;
               err_n   = 1'b0;
            end
         end
         // Stage p0 -> p1: encode the accepted beat into the write register
         S_ACCEPT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               word_n  = enc_word;
               last_n  = in_last;
               err_n   = err_q | enc_bad;
               state_n = S_WRITE;
            end
         end
         S_WRITE: begin
            imem_we = 1'b1;
            busy    = 1'b1;
            addr_n  = addr_q + 1'b1;
            count_n = count_q + 1'b1;
            if (last_p1) begin
               state_n = S_DONE;
            end else if (count_q == LAST_CNT) begin
               // memory full without a final beat: stop and flag the truncation
               state_n = S_DONE;
               err_n   = 1'b1;
            end else begin
               state_n = S_ACCEPT;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) begin
               state_n = S_ACCEPT;
               addr_n  = '0;
               count_n = '0;
               err_n   = 1'b0;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign imem_addr  = addr_q;
   assign imem_wdata = word_p1;
   assign err        = err_q;
   assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a 4-word memory session limit.
module tb_instr_encoder_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_kind;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic        in_funct7b5;
   logic [20:0] in_imm;
   logic        in_last;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [6:0]  count;

   int checks;
   int failures;

   instr_encoder_loader #(.ADDR_W(6), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_kind     (in_kind),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_funct3   (in_funct3),
      .in_funct7b5 (in_funct7b5),
      .in_imm      (in_imm),
      .in_last     (in_last),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"}, in_ready, 0);
      chk({tag, "_we"}, imem_we, 0);
      chk({tag, "_addr"}, imem_addr, 0);
      chk({tag, "_wdata"}, imem_wdata, 0);
      chk({tag, "_hold"}, cpu_hold, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_count"}, count, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called just after a negedge; returns one negedge after the WRITE cycle.
   task automatic send(input string tag, input logic [2:0] k, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic f7, input logic [20:0] imm, input logic last,
                       input logic [31:0] exp_w, input logic [5:0] exp_a);
      int n;
      in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7b5 = f7; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, in_ready, 1);
      chk({tag, "_we_pre"}, imem_we, 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_we"}, imem_we, 1);
      chk({tag, "_addr"}, imem_addr, exp_a);
      chk({tag, "_wdata"}, imem_wdata, exp_w);
      chk({tag, "_ready_wr"}, in_ready, 0);
      @(negedge clk);
      chk({tag, "_we_off"}, imem_we, 0);
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0;
      in_kind = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
      in_funct3 = 3'd0; in_funct7b5 = 1'b0; in_imm = 21'd0; in_last = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // single I-ALU program
      pulse_start();
      chk("s1_busy", busy, 1);
      chk("s1_hold", cpu_hold, 1);
      send("addi", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b1, 32'h0050_0093, 6'd0);
      chk("s1_done", done, 1);
      chk("s1_hold_rel", cpu_hold, 0);
      chk("s1_busy_end", busy, 0);
      chk("s1_count", count, 1);
      chk("s1_err", err, 0);

      // restart from DONE, four-word stream
      pulse_start();
      chk("s2_done", done, 0);
      chk("s2_hold", cpu_hold, 1);
      chk("s2_count", count, 0);
      send("add", 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b0, 32'h0020_81B3, 6'd0);
      send("sw", 3'd3, 5'd0, 5'd0, 5'd2, 3'd2, 1'b0, 21'd8, 1'b0, 32'h0020_2423, 6'd1);
      send("beq", 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1F_FFFC, 1'b0, 32'hFE00_0EE3, 6'd2);
      send("jal", 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1, 32'h0080_00EF, 6'd3);
      chk("s2_done_end", done, 1);
      chk("s2_count_end", count, 4);
      chk("s2_err", err, 0);

      // range violations and illegal kind
      pulse_start();
      send("br_odd", 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5, 1'b0, 32'h0000_0013, 6'd0);
      chk("s3_err_odd", err, 1);
      send("kind7", 3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 21'd0, 1'b0, 32'h0000_0013, 6'd1);
      chk("s3_err_k7", err, 1);
      send("addi_big", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048, 1'b0, 32'h0000_0013, 6'd2);
      send("addi_min", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1F_F800, 1'b1, 32'h8000_0093, 6'd3);
      chk("s3_done", done, 1);
      chk("s3_err_end", err, 1);

      // overflow: four beats without last
      pulse_start();
      chk("s4_err_clr", err, 0);
      send("ov0", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd0, 1'b0, 32'h0000_0093, 6'd0);
      send("ov1", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd1, 1'b0, 32'h0010_0093, 6'd1);
      send("ov2", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2, 1'b0, 32'h0020_0093, 6'd2);
      send("ov3", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd3, 1'b0, 32'h0030_0093, 6'd3);
      chk("s4_done", done, 1);
      chk("s4_err", err, 1);
      chk("s4_count", count, 4);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("s4_ready_blk", in_ready, 0);
         chk("s4_we_blk", imem_we, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("s4_count_hold", count, 4);

      // asynchronous reset during WRITE
      pulse_start();
      in_kind = 3'd6; in_last = 1'b0; in_imm = 21'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      chk("s5_we_before", imem_we, 1);
      chk("s5_err_before", err, 1);
      reset = 1'b1;
      #1;
      in_valid = 1'b0;
      check_reset_values("s5_async");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pulse_start();
      send("post_rst", 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd7, 1'b1, 32'h0070_0093, 6'd0);
      chk("s5_err_after", err, 0);
      chk("s5_count", count, 1);
      chk("s5_done", done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
